x7seg_scan_capture: RTL and testbench

//  Receive end of the multiplexed 7-segment scan interface (a_to_g / an / dp).

---
 rtl/x7seg_scan_capture_pkg.sv | 31 +++
 rtl/x7seg_scan_capture_if.sv | 24 ++
 rtl/x7seg_scan_capture_pat_decode.sv | 35 +++
 rtl/x7seg_scan_capture.sv | 191 +++++++++++++++++++
 tb/tb_x7seg_scan_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/x7seg_scan_capture_pkg.sv
// x7seg_pkg: segment pattern table and frame state shared with the driver.
// Patterns are active low, bit6 = a ... bit0 = g.
package x7seg_pkg;

    localparam int SLOTS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    typedef enum logic {
        IDLE,
        RUN
    } cap_state_t;

endpackage

// File: rtl/x7seg_scan_capture_if.sv
// x7seg_scan_capture_if: scan pins from the display driver plus the
// reconstructed frame results; master = driver side, slave = capture side.
interface x7seg_scan_capture_if;

    logic [6:0]  a_to_g;
    logic [7:0]  an;
    logic        dp;
    logic [15:0] score;
    logic [3:0]  blank;
    logic        valid;
    logic        link_ok;
    logic        err;

    modport master (
        output a_to_g, an, dp,
        input  score, blank, valid, link_ok, err
    );

    modport slave (
        input  a_to_g, an, dp,
        output score, blank, valid, link_ok, err
    );

endinterface

// File: rtl/x7seg_scan_capture_pat_decode.sv
// x7seg_pat_decode: active-low segment pattern -> hex digit.
// hit = 0 for any pattern outside the table; digit is then 0.
module x7seg_pat_decode (
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] digit
);
    import x7seg_pkg::*;

    // table lookup, unknown patterns miss
    always_comb begin
        hit   = 1'b1;
        digit = 4'h0;
        case (seg)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/x7seg_scan_capture.sv
// x7seg_scan_capture: rebuilds the 4-digit hex value from the scan pins.
// Define X7SEG_CAP_SYNC_EN to add a 2-flop synchronizer on a_to_g/an.
module x7seg_scan_capture #(
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 1024
) (
    input logic                 cclk,
    input logic                 clr_n,
    x7seg_scan_capture_if.slave bus
);
    import x7seg_pkg::*;

    localparam int CW = $clog2(STABLE_CNT + 1);

    logic [3:0] y_an;
    logic [6:0] y_seg;

`ifdef X7SEG_CAP_SYNC_EN
    logic [3:0] m_an, q_an;
    logic [6:0] m_seg, q_seg;

    // two-flop synchronizer for pins from another clock domain
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            m_an  <= 4'hF;
            q_an  <= 4'hF;
            m_seg <= SEG_BLANK;
            q_seg <= SEG_BLANK;
        end else begin
            m_an  <= bus.an[3:0];
            q_an  <= m_an;
            m_seg <= bus.a_to_g;
            q_seg <= m_seg;
        end
    end

    assign y_an  = q_an;
    assign y_seg = q_seg;
`else
    assign y_an  = bus.an[3:0];
    assign y_seg = bus.a_to_g;
`endif

    logic [3:0] s_an;
    logic [6:0] s_seg;

    // sample register feeding the decode path
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            s_an  <= 4'hF;
            s_seg <= SEG_BLANK;
        end else begin
            s_an  <= y_an;
            s_seg <= y_seg;
        end
    end

    logic       act;
    logic       ill;
    logic [1:0] slot;

    // one low strobe selects a slot, all high is idle, else illegal
    always_comb begin
        act  = 1'b0;
        ill  = 1'b0;
        slot = 2'd0;
        case (s_an)
            4'b1110: begin act = 1'b1; slot = 2'd0; end
            4'b1101: begin act = 1'b1; slot = 2'd1; end
            4'b1011: begin act = 1'b1; slot = 2'd2; end
            4'b0111: begin act = 1'b1; slot = 2'd3; end
            4'b1111: ;
            default: ill = 1'b1;
        endcase
    end

    logic       hit;
    logic [3:0] dig;

    x7seg_pat_decode u_dec (
        .seg   (s_seg),
        .hit   (hit),
        .digit (dig)
    );

    logic [9:0]    key, p_key;
    logic          p_ok;
    logic          same;
    logic          acc;
    logic [CW-1:0] cnt, cnt_nxt;

    assign key  = {act, slot, s_seg};
    assign same = p_ok && (key == p_key);

    // count saturates so a held slot is accepted only once
    always_comb begin
        cnt_nxt = CW'(1);
        if (same)
            cnt_nxt = (cnt == CW'(STABLE_CNT)) ? cnt : cnt + CW'(1);
    end

    assign acc = act && (cnt_nxt == CW'(STABLE_CNT))
               && !(same && cnt == CW'(STABLE_CNT));

    // stability tracking; illegal samples restart it
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            cnt   <= '0;
            p_ok  <= 1'b0;
            p_key <= '0;
        end else if (ill) begin
            cnt   <= '0;
            p_ok  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            p_ok  <= 1'b1;
            p_key <= key;
        end
    end

    cap_state_t             state;
    logic [SLOTS-1:0][3:0]  buf_dig;
    logic [SLOTS-1:0]       seen;
    logic [15:0]            tcnt, tcnt_nxt;
    logic                   tmo;
    logic                   acc0;
    logic [15:0]            score_q;
    logic [3:0]             blank_q;
    logic                   valid_q, link_q, err_q;

    assign acc0 = acc && (slot == 2'd0);

    // link watchdog: cleared by slot 0, saturates at TIMEOUT
    always_comb begin
        tcnt_nxt = tcnt;
        if (acc0)
            tcnt_nxt = 16'd0;
        else if (tcnt != 16'(TIMEOUT))
            tcnt_nxt = tcnt + 16'd1;
    end

    assign tmo = (tcnt_nxt == 16'(TIMEOUT));

    // frame FSM: slot 0 closes the previous frame and opens the next
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            buf_dig <= '0;
            seen    <= '0;
            tcnt    <= 16'd0;
            score_q <= 16'd0;
            blank_q <= 4'b1110;
            valid_q <= 1'b0;
            link_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            tcnt    <= tcnt_nxt;
            if (ill || (acc && !hit))
                err_q <= 1'b1;
            if (acc) begin
                buf_dig[slot] <= dig;
                seen[slot]    <= 1'b1;
            end
            if (acc0) begin
                seen[3:1] <= 3'b000;
                state     <= RUN;
                if (state == RUN) begin
                    for (int i = 0; i < SLOTS; i++)
                        score_q[4*i +: 4] <= seen[i] ? buf_dig[i] : 4'h0;
                    blank_q <= {~seen[3:1], 1'b0};
                    valid_q <= 1'b1;
                    link_q  <= 1'b1;
                end
            end else if (tmo) begin
                link_q <= 1'b0;
                state  <= IDLE;
            end
        end
    end

    assign bus.score   = score_q;
    assign bus.blank   = blank_q;
    assign bus.valid   = valid_q;
    assign bus.link_ok = link_q;
    assign bus.err     = err_q;

    logic unused_pins;
    assign unused_pins = &{1'b0, bus.dp, bus.an[7:4]};

endmodule

// File: tb/tb_x7seg_scan_capture.sv
// tb_x7seg_scan_capture: directed scan frames with hand-computed results.
// Expected decode latency depends on X7SEG_CAP_SYNC_EN.
module tb_x7seg_scan_capture;

    localparam int TIMEOUT = 1024;
`ifdef X7SEG_CAP_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic cclk  = 1'b0;
    logic clr_n = 1'b0;
    int   nchk  = 0;
    int   nerr  = 0;
    int   cyc   = 0;
    int   nvalid = 0;
    int   last_vcyc = 0;

    x7seg_scan_capture_if bus ();

    x7seg_scan_capture #(
        .STABLE_CNT (2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .cclk  (cclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 cclk = ~cclk;

    // count valid pulses away from the active edge
    always @(negedge cclk) begin
        cyc++;
        if (bus.valid === 1'b1) begin
            nvalid++;
            last_vcyc = cyc;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h01;
            4'h1: return 7'h4F;
            4'h2: return 7'h12;
            4'h3: return 7'h06;
            4'h4: return 7'h4C;
            4'h5: return 7'h24;
            4'h6: return 7'h20;
            4'h7: return 7'h0F;
            4'h8: return 7'h00;
            4'h9: return 7'h04;
            4'hA: return 7'h08;
            4'hB: return 7'h60;
            4'hC: return 7'h31;
            4'hD: return 7'h42;
            4'hE: return 7'h30;
            default: return 7'h38;
        endcase
    endfunction

    function automatic logic [7:0] anode(input int k);
        return ~(8'h01 << k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge cclk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s,
                         input int n);
        bus.an     = a;
        bus.a_to_g = s;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        drive(8'hFF, 7'h7F, n);
    endtask

    task automatic frame_seg(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] on);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            if (on[k]) drive(anode(k), s[k], 4);
            else       idle(4);
        end
    endtask

    task automatic frame(input logic [15:0] v);
        frame_seg(seg7(v[3:0]), seg7(v[7:4]),
                  seg7(v[11:8]), seg7(v[15:12]), 4'hF);
    endtask

    initial begin
        int v0;
        int n;
        bus.an     = 8'hFF;
        bus.a_to_g = 7'h7F;
        bus.dp     = 1'b1;
        clr_n      = 1'b0;
        repeat (3) tick();

        check("rst score",   32'(bus.score),   32'h0);
        check("rst blank",   32'(bus.blank),   32'hE);
        check("rst valid",   32'(bus.valid),   32'h0);
        check("rst link_ok", 32'(bus.link_ok), 32'h0);
        check("rst err",     32'(bus.err),     32'h0);

        clr_n = 1'b1;
        idle(3);

        // 1: three frames of 1234
        v0 = nvalid;
        repeat (3) frame(16'h1234);
        check("t1 valid cnt", 32'(nvalid - v0), 32'd2);
        check("t1 score",     32'(bus.score),   32'h1234);
        check("t1 blank",     32'(bus.blank),   32'h0);
        check("t1 link_ok",   32'(bus.link_ok), 32'h1);
        check("t1 err",       32'(bus.err),     32'h0);

        // 2: only slot 0 strobed
        v0 = nvalid;
        repeat (2) frame_seg(seg7(4'h5), 7'h7F, 7'h7F, 7'h7F, 4'b0001);
        check("t2 valid cnt", 32'(nvalid - v0), 32'd2);
        check("t2 score",     32'(bus.score),   32'h0005);
        check("t2 blank",     32'(bus.blank),   32'hE);
        check("t2 link_ok",   32'(bus.link_ok), 32'h1);

        // 3: two anodes low at once
        drive(8'hFC, seg7(4'h1), 3);
        idle(3);
        check("t3 err", 32'(bus.err), 32'h1);
        bus.dp = 1'b0;
        v0 = nvalid;
        repeat (2) frame(16'h9C60);
        bus.dp = 1'b1;
        check("t3 valid cnt", 32'(nvalid - v0), 32'd2);
        check("t3 score",     32'(bus.score),   32'h9C60);
        check("t3 blank",     32'(bus.blank),   32'h0);

        // 4: unlisted pattern on slot 2
        clr_n = 1'b0;
        tick();
        check("t4 err clr", 32'(bus.err), 32'h0);
        clr_n = 1'b1;
        idle(2);
        v0 = nvalid;
        repeat (2) frame_seg(seg7(4'hA), seg7(4'hF), 7'h7F,
                             seg7(4'h3), 4'hF);
        check("t4 valid cnt", 32'(nvalid - v0),     32'd1);
        check("t4 err",       32'(bus.err),         32'h1);
        check("t4 score",     32'(bus.score),       32'h30FA);
        check("t4 digit2",    32'(bus.score[11:8]), 32'h0);
        check("t4 blank",     32'(bus.blank),       32'h0);

        // 5: stop after BEEF, watch the link drop
        repeat (2) frame(16'hBEEF);
        check("t5 score", 32'(bus.score), 32'hBEEF);
        idle(1);
        n = 0;
        while (bus.link_ok === 1'b1 && n < 1500) begin
            tick();
            n++;
        end
        check("t5 link drop", 32'(bus.link_ok), 32'h0);
        check("t5 drop delay", 32'(cyc - last_vcyc), 32'(TIMEOUT));
        check("t5 score held", 32'(bus.score), 32'hBEEF);
        check("t5 blank held", 32'(bus.blank), 32'h0);

        // 6: reset in the middle of a frame
        drive(anode(0), seg7(4'h8), 4);
        drive(anode(1), seg7(4'h7), 2);
        clr_n = 1'b0;
        #1;
        check("t6 score",   32'(bus.score),   32'h0);
        check("t6 valid",   32'(bus.valid),   32'h0);
        check("t6 link_ok", 32'(bus.link_ok), 32'h0);
        check("t6 blank",   32'(bus.blank),   32'hE);
        idle(2);
        clr_n = 1'b1;
        idle(3);
        v0 = nvalid;
        frame(16'h5678);
        check("t6 no valid", 32'(nvalid - v0), 32'd0);
        check("t6 score 0",  32'(bus.score),   32'h0);
        bus.an     = anode(0);
        bus.a_to_g = seg7(4'h8);
        n = 0;
        while (bus.valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t6 latency", 32'(n),           32'(LAT));
        check("t6 score",   32'(bus.score),   32'h5678);
        check("t6 blank",   32'(bus.blank),   32'h0);
        check("t6 link_ok", 32'(bus.link_ok), 32'h1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
